// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the framed-byte instruction-memory loader.
// Frame layout: SYNC, length (LEN_BYTES little-endian), length * WORD_BYTES data bytes, XOR checksum.
package inst_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_e;

  localparam logic [7:0] SYNC_DEFAULT  = 8'hA5;
  localparam int         DEPTH_DEFAULT = 1024;
  localparam int         LEN_BYTES     = 2;
  localparam int         WORD_BYTES    = 4;
  localparam int         LEN_W         = 8 * LEN_BYTES;
  localparam int         WORD_W        = 8 * WORD_BYTES;

endpackage

// File: rtl/loader_word_assembler.sv
// Collects WORD_BYTES stream bytes little-endian and presents the finished word
// with a one-cycle word_ready pulse on the cycle after its last byte.
module loader_word_assembler
  import inst_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic              last_byte,
  output logic              word_ready,
  output logic [WORD_W-1:0] word_out
);

  localparam int IDX_W = $clog2(WORD_BYTES);

  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              word_ready_q, word_ready_d;

  assign last_byte  = (byte_idx_q == IDX_W'(WORD_BYTES - 1));
  assign word_ready = word_ready_q;
  assign word_out   = word_q;

  always_comb begin
    byte_idx_d   = byte_idx_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_ready_d = 1'b0;
    if (clear) begin
      byte_idx_d = '0;
      shift_d    = '0;
    end else if (byte_valid) begin
      // First byte ends up in the low lane after WORD_BYTES right shifts.
      shift_d    = {byte_in, shift_q[WORD_W-1:8]};
      byte_idx_d = byte_idx_q + 1'b1;
      if (last_byte) begin
        word_ready_d = 1'b1;
        word_d       = {byte_in, shift_q[WORD_W-1:8]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_q   <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_ready_q <= 1'b0;
    end else begin
      byte_idx_q   <= byte_idx_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_ready_q <= word_ready_d;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Write side of the instruction memory: parses a framed byte stream, writes
// zero-extended 32-bit words from address 0 and holds Inst_wr while loading.
//
// state | meaning
// IDLE  | hunting for SYNC, other bytes dropped
// LEN0  | length low byte
// LEN1  | length high byte, range check
// DATA  | word bytes, one memory write per word
// CHK   | compare checksum byte with running XOR
// DONE  | one-cycle completion, in_ready low
// ERR   | frame rejected, drain bytes until rst
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int         DEPTH = DEPTH_DEFAULT,
  parameter logic [7:0] SYNC  = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        Inst_wr,
  output logic        mem_wr,
  output logic [63:0] mem_addr,
  output logic [63:0] Inst_to_wr,
  output logic        done,
  output logic        err
);

  localparam int                 IDX_W     = $clog2(DEPTH + 1);
  localparam logic [LEN_W:0]     DEPTH_LIM = (LEN_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [LEN_W-1:0]  words_left_q, words_left_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic [7:0]        chk_q, chk_d;
  logic              inst_wr_q, inst_wr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic [LEN_W:0]    len_full;
  logic              asm_clear;
  logic              asm_valid;
  logic              asm_last_byte;
  logic              asm_word_ready;
  logic [WORD_W-1:0] asm_word;

  // DONE is the only state that refuses bytes, so a back-to-back SYNC waits for IDLE.
  assign in_ready  = (state_q != ST_DONE);
  assign xfer      = in_valid & in_ready;
  assign len_full  = {1'b0, in_data, len_lo_q};
  assign asm_clear = (state_q != ST_DATA);
  assign asm_valid = xfer & (state_q == ST_DATA);

  loader_word_assembler u_word_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_in    (in_data),
    .last_byte  (asm_last_byte),
    .word_ready (asm_word_ready),
    .word_out   (asm_word)
  );

  // The write cycle follows the 4th byte; the last word's write lands in CHK's first cycle.
  assign mem_wr     = asm_word_ready;
  assign mem_addr   = 64'(word_idx_q);
  assign Inst_to_wr = {{(64 - WORD_W){1'b0}}, asm_word};
  assign Inst_wr    = inst_wr_q;
  assign done       = done_q;
  assign err        = err_q;

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    words_left_d = words_left_q;
    word_idx_d   = word_idx_q;
    chk_d        = chk_q;
    inst_wr_d    = inst_wr_q;
    done_d       = done_q;
    err_d        = err_q;

    if (asm_word_ready) begin
      word_idx_d = word_idx_q + IDX_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (xfer && (in_data == SYNC)) begin
          state_d   = ST_LEN0;
          inst_wr_d = 1'b1;
          done_d    = 1'b0;
          chk_d     = '0;
        end
      end
      ST_LEN0: begin
        if (xfer) begin
          len_lo_d = in_data;
          chk_d    = chk_q ^ in_data;
          state_d  = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (xfer) begin
          chk_d        = chk_q ^ in_data;
          words_left_d = len_full[LEN_W-1:0];
          if (len_full > DEPTH_LIM) begin
            state_d   = ST_ERR;
            inst_wr_d = 1'b0;
            err_d     = 1'b1;
          end else if (len_full == '0) begin
            state_d = ST_CHK;
          end else begin
            state_d    = ST_DATA;
            word_idx_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          chk_d = chk_q ^ in_data;
          if (asm_last_byte) begin
            words_left_d = words_left_q - LEN_W'(1);
            if (words_left_q == LEN_W'(1)) begin
              state_d = ST_CHK;
            end
          end
        end
      end
      ST_CHK: begin
        if (xfer) begin
          inst_wr_d = 1'b0;
          if (in_data == chk_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_lo_q     <= '0;
      words_left_q <= '0;
      word_idx_q   <= '0;
      chk_q        <= '0;
      inst_wr_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      words_left_q <= words_left_d;
      word_idx_q   <= word_idx_d;
      chk_q        <= chk_d;
      inst_wr_q    <= inst_wr_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed and randomized frames against a frame-level reference model;
// a negedge monitor checks write timing, addresses and data.
module tb_inst_mem_loader;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        Inst_wr;
  logic        mem_wr;
  logic [63:0] mem_addr;
  logic [63:0] Inst_to_wr;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [7:0]  frame_q[$];
  logic [31:0] payload_q[$];
  bit          wend_q[$];
  wr_t         exp_q[$];
  logic        exp_done, exp_err;
  int          sync_pos;

  bit          wend_flag = 1'b0;
  bit          mon_en = 1'b0;
  logic        pend_wr = 1'b0;
  wr_t         got_e;

  inst_mem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .Inst_wr    (Inst_wr),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .Inst_to_wr (Inst_to_wr),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // A write is due exactly one cycle after the transfer of a word's final byte.
  always @(negedge clk) begin
    if (mon_en) begin
      check("mem_wr_timing", 64'(mem_wr), 64'(pend_wr));
      if (mem_wr === 1'b1) begin
        check("write_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          got_e = exp_q.pop_front();
          check("mem_addr", mem_addr, got_e.addr);
          check("Inst_to_wr", Inst_to_wr, got_e.data);
        end
      end
    end
    pend_wr <= in_valid & in_ready & wend_flag & ~rst;
  end

  // Reference model: parse the frame by its byte layout, predict writes and outcome.
  task automatic model_frame();
    int p;
    int cnt;
    int b;
    logic [7:0] x;
    logic [31:0] w;
    wr_t e;
    wend_q.delete();
    foreach (frame_q[i]) wend_q.push_back(1'b0);
    p = 0;
    while (p < frame_q.size() && frame_q[p] != 8'hA5) p++;
    sync_pos = p;
    cnt = int'(frame_q[p+1]) + 256 * int'(frame_q[p+2]);
    x = frame_q[p+1] ^ frame_q[p+2];
    if (cnt > 1024) begin
      exp_err = 1'b1;
      exp_done = 1'b0;
      return;
    end
    for (int k = 0; k < cnt; k++) begin
      b = p + 3 + 4 * k;
      w = {frame_q[b+3], frame_q[b+2], frame_q[b+1], frame_q[b]};
      x ^= frame_q[b] ^ frame_q[b+1] ^ frame_q[b+2] ^ frame_q[b+3];
      e.addr = 64'(k);
      e.data = {32'd0, w};
      exp_q.push_back(e);
      wend_q[b+3] = 1'b1;
    end
    exp_done = (frame_q[p + 3 + 4 * cnt] == x);
    exp_err = ~exp_done;
  endtask

  task automatic build_frame(input int garbage, input bit bad_chk, input bit trailing);
    logic [7:0] x;
    logic [7:0] g;
    int cnt;
    frame_q.delete();
    cnt = payload_q.size();
    for (int i = 0; i < garbage; i++) begin
      g = 8'($urandom_range(0, 255));
      if (g == 8'hA5) g = 8'h11;
      frame_q.push_back(g);
    end
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'(cnt));
    frame_q.push_back(8'(cnt >> 8));
    x = 8'(cnt) ^ 8'(cnt >> 8);
    foreach (payload_q[i]) begin
      for (int j = 0; j < 4; j++) begin
        frame_q.push_back(payload_q[i][8*j +: 8]);
        x ^= payload_q[i][8*j +: 8];
      end
    end
    frame_q.push_back(bad_chk ? (x ^ 8'h01) : x);
    if (trailing) begin
      frame_q.push_back(8'hA5);
      frame_q.push_back(8'h00);
      frame_q.push_back(8'h00);
      frame_q.push_back(8'h00);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit wend, input int idle);
    int guard;
    for (int i = 0; i < idle; i++) begin
      in_valid = 1'b0;
      in_data = 8'($urandom_range(0, 255));
      wend_flag = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data = b;
    wend_flag = wend;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wend_flag = 1'b0;
  endtask

  task automatic send_frame(input int idle_mode, input int n_bytes);
    int idle;
    for (int i = 0; i < n_bytes; i++) begin
      idle = (idle_mode == 1) ? 1 : (idle_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      send_byte(frame_q[i], wend_q[i], idle);
      if (i == sync_pos) begin
        check("inst_wr_after_sync", 64'(Inst_wr), 64'd1);
        check("done_cleared_on_sync", 64'(done), 64'd0);
      end
    end
  endtask

  task automatic run_frame(input string name, input int idle_mode);
    model_frame();
    send_frame(idle_mode, frame_q.size());
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done"}, 64'(done), 64'(exp_done));
    check({name, "_err"}, 64'(err), 64'(exp_err));
    check({name, "_inst_wr"}, 64'(Inst_wr), 64'd0);
    check({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    check({name, "_Inst_wr"}, 64'(Inst_wr), 64'd0);
    check({name, "_mem_wr"}, 64'(mem_wr), 64'd0);
    check({name, "_mem_addr"}, mem_addr, 64'd0);
    check({name, "_Inst_to_wr"}, Inst_to_wr, 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    // Two known words, good checksum.
    payload_q = '{32'h0000_0013, 32'h0000_0133};
    build_frame(0, 1'b0, 1'b0);
    run_frame("good2", 0);

    // Same words, corrupted checksum, then bytes that must be drained.
    build_frame(0, 1'b1, 1'b1);
    run_frame("badchk", 0);
    check("badchk_err_sticky", 64'(err), 64'd1);
    do_reset();

    // Length 1025 exceeds depth.
    frame_q = '{8'hA5, 8'h01, 8'h04, 8'h13, 8'h00, 8'h00, 8'h00};
    run_frame("toolong", 0);
    do_reset();

    // Exactly DEPTH words would be legal; length 0 with leading garbage.
    payload_q.delete();
    build_frame(2, 1'b0, 1'b0);
    frame_q[0] = 8'h11;
    frame_q[1] = 8'h22;
    run_frame("len0", 0);

    // Three random words with in_valid toggling every other cycle.
    payload_q.delete();
    repeat (3) payload_q.push_back($urandom);
    build_frame(0, 1'b0, 1'b0);
    run_frame("toggle3", 1);
    build_frame(0, 1'b0, 1'b0);
    run_frame("b2b3", 0);

    // Randomized frames with random gaps, garbage and occasional bad checksums.
    for (int f = 0; f < 6; f++) begin
      payload_q.delete();
      repeat ($urandom_range(1, 5)) payload_q.push_back($urandom);
      build_frame($urandom_range(0, 3), (f % 3) == 2, 1'b0);
      run_frame("rand", 2);
      if (exp_err) do_reset();
    end

    // Reset after 6 data bytes of a 2-word frame: one write, then clean restart.
    payload_q.delete();
    repeat (2) payload_q.push_back($urandom);
    build_frame(0, 1'b0, 1'b0);
    model_frame();
    send_frame(0, 9);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values("midrst");
    rst = 1'b0;
    check("midrst_unwritten", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    build_frame(1, 1'b0, 1'b0);
    run_frame("after_rst", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
